// File: rtl/manual_clock_debouncer.sv
// manual_clock_debouncer: synchronise and debounce the manual clock button and clock-mode switch
module manual_clock_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic       CLKFPGA,
  input  logic       Reset,
  input  logic       KEY,
  input  logic       SW,
  output logic       CLKManual,
  output logic       CLKManualPulse,
  output logic       CTRLCLK,
  output logic [7:0] PressCount
);
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  logic [1:0] r_key_q, r_sw_q;
  logic [CNT_WIDTH-1:0] r_bcnt, r_scnt;
  logic [7:0] r_count;
  logic r_pulse, r_ctrl;
  state_t r_state, w_next;
  logic w_key_s, w_sw_s, w_bdone, w_chk, w_accept;
  assign w_key_s = r_key_q[1];
  assign w_sw_s  = r_sw_q[1];
  assign w_bdone = r_bcnt == LAST;
  assign w_chk   = r_state == PRESS_CHK || r_state == RELEASE_CHK;
  // two-flop synchronisers; the button idles released (high), the switch in divided mode
  always_ff @(posedge CLKFPGA) begin
    r_key_q <= Reset ? 2'b11 : {r_key_q[0], KEY};
    r_sw_q  <= Reset ? 2'b00 : {r_sw_q[0], SW};
  end
  // button state register
  always_ff @(posedge CLKFPGA) r_state <= Reset ? RELEASED : w_next;
  // button next state: a check state needs STABLE_CYCLES more agreeing samples to commit
  always_comb begin
    w_next = r_state;
    case (r_state)
      RELEASED:    w_next = w_key_s ? RELEASED : PRESS_CHK;
      PRESS_CHK:   w_next = w_key_s ? RELEASED : (w_bdone ? PRESSED : PRESS_CHK);
      PRESSED:     w_next = w_key_s ? RELEASE_CHK : PRESSED;
      RELEASE_CHK: w_next = !w_key_s ? PRESSED : (w_bdone ? RELEASED : RELEASE_CHK);
      default:     w_next = RELEASED;
    endcase
  end
  // button outputs: level straight from the state register, press accepted on PRESS_CHK exit
  always_comb begin
    CLKManual = r_state == PRESSED || r_state == RELEASE_CHK;
    w_accept  = r_state == PRESS_CHK && w_next == PRESSED;
  end
  // qualification counter runs only while lingering in a check state
  always_ff @(posedge CLKFPGA) r_bcnt <= (Reset || !w_chk || w_next != r_state) ? '0 : r_bcnt + 1'b1;
  // one-cycle press pulse and wrapping press counter
  always_ff @(posedge CLKFPGA) begin
    r_pulse <= Reset ? 1'b0 : w_accept;
    r_count <= Reset ? 8'd0 : r_count + 8'(w_accept);
  end
  // switch filter: adopt the synchronised level after STABLE_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLKFPGA) begin
    if (Reset || w_sw_s == r_ctrl) begin
      r_scnt <= '0;
      r_ctrl <= Reset ? 1'b0 : r_ctrl;
    end else if (r_scnt == LAST) begin
      r_scnt <= '0;
      r_ctrl <= w_sw_s;
    end else begin
      r_scnt <= r_scnt + 1'b1;
    end
  end
  assign CLKManualPulse = r_pulse;
  assign CTRLCLK        = r_ctrl;
  assign PressCount     = r_count;
endmodule

// File: tb/tb_manual_clock_debouncer.sv
// tb_manual_clock_debouncer: scoreboard bench for the button/switch debouncer
module tb_manual_clock_debouncer;
  localparam int S = 4;
  logic clk = 0, rst, key, sw;
  logic man, pulse, ctrl;
  logic [7:0] cnt;
  int checks = 0, errors = 0, pulses = 0, edges = 0, rise_edge = 0;
  logic [10:0] exp_q[$];
  logic m_k1, m_k2, m_s1, m_s2, m_man, m_pulse, m_ctrl;
  logic [7:0] m_cnt;
  int brun, srun;

  manual_clock_debouncer #(.STABLE_CYCLES(S), .CNT_WIDTH(3)) dut (
    .CLKFPGA(clk), .Reset(rst), .KEY(key), .SW(sw),
    .CLKManual(man), .CLKManualPulse(pulse), .CTRLCLK(ctrl), .PressCount(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: accepted level changes after a run of consecutive disagreeing synchronised samples
  task automatic model_step();
    logic want;
    if (rst) begin
      {m_k1, m_k2, m_s1, m_s2} = 4'b1100;
      {m_man, m_pulse, m_ctrl} = 3'b000;
      m_cnt = 0; brun = 0; srun = 0;
    end else begin
      m_pulse = 0;
      want = ~m_k2;
      if (want != m_man) begin
        brun++;
        if (brun == S + 1) begin
          m_man = want; brun = 0;
          if (want) begin m_pulse = 1; m_cnt++; end
        end
      end else brun = 0;
      if (m_s2 != m_ctrl) begin
        srun++;
        if (srun == S) begin m_ctrl = m_s2; srun = 0; end
      end else srun = 0;
      m_k2 = m_k1; m_k1 = key;
      m_s2 = m_s1; m_s1 = sw;
    end
  endtask

  task automatic tick(input string tag);
    logic [10:0] e;
    model_step();
    exp_q.push_back({m_man, m_pulse, m_ctrl, m_cnt});
    @(posedge clk);
    #1;
    edges++;
    if (pulse) pulses++;
    if (man && rise_edge == 0) rise_edge = edges;
    e = exp_q.pop_front();
    check(tag, {man, pulse, ctrl, cnt}, e);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst = 1; key = 1; sw = 0;
    ticks("reset", 2);
    check("reset_vals", {man, pulse, ctrl, cnt}, 11'd0);
    rst = 0;
    ticks("idle", 20);
    check("idle_vals", {man, pulse, ctrl, cnt}, 11'd0);
    // clean press: rise after edge S+3 counted from the first low sample
    pulses = 0; edges = 0; rise_edge = 0; key = 0;
    ticks("press", 20);
    check("rise_edge", rise_edge, S + 3);
    check("one_pulse", pulses, 1);
    check("count1", cnt, 1);
    key = 1;
    ticks("release_hold", S + 2);
    check("still_high", man, 1);
    tick("release_fall");
    check("fell", man, 0);
    ticks("release_idle", 5);
    // press bounce shorter than the window
    pulses = 0;
    key = 0; ticks("bounce_lo", 3);
    key = 1; ticks("bounce_hi", 1);
    key = 0; ticks("bounce_lo2", 3);
    key = 1; ticks("bounce_end", 12);
    check("bounce_pulses", pulses, 0);
    check("bounce_count", cnt, 1);
    // release bounce while pressed
    key = 0; ticks("press2", 12);
    pulses = 0;
    key = 1; ticks("rel_bounce_hi", 2);
    key = 0; ticks("rel_bounce_lo", 12);
    check("rel_bounce_man", man, 1);
    check("rel_bounce_pulses", pulses, 0);
    check("rel_bounce_count", cnt, 2);
    key = 1; ticks("rel2", 12);
    // 256 presses wrap the counter back to its starting value
    pulses = 0;
    for (int p = 0; p < 256; p++) begin
      key = 0; ticks("wrap_press", 8);
      key = 1; ticks("wrap_release", 8);
    end
    check("wrap_pulses", pulses, 256);
    check("wrap_count", cnt, 2);
    // switch to manual mode: CTRLCLK after edge S+2
    edges = 0; sw = 1;
    ticks("sw_wait", S + 1);
    check("sw_not_yet", ctrl, 0);
    tick("sw_edge");
    check("sw_set", ctrl, 1);
    sw = 0; ticks("sw_glitch", 2);
    sw = 1; ticks("sw_hold", 8);
    check("sw_glitch_kept", ctrl, 1);
    // press and switch change together
    key = 0; sw = 0; ticks("simul", 10);
    check("simul_man", man, 1);
    check("simul_ctrl", ctrl, 0);
    key = 1; ticks("simul_rel", 10);
    // reset while in PRESS_CHK with bcnt=2
    pulses = 0; sw = 1;
    key = 0; ticks("pre_reset", 5);
    rst = 1; tick("mid_reset");
    check("mid_reset_vals", {man, pulse, ctrl, cnt}, 11'd0);
    rst = 0; key = 1; ticks("post_reset", 10);
    check("mid_reset_pulses", pulses, 0);
    check("post_reset_count", cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/manual_clock_debouncer.md
# manual_clock_debouncer

Conditioning stage for the manual clock push button and the clock-mode switch. It sits directly upstream of the clock selector. Both raw board inputs are synchronised to CLKFPGA and debounced. The block drives the selector's CLKManual and CTRLCLK inputs, and also provides a single-cycle press pulse and a press counter for the display logic.

## Interface
Parameters:
- STABLE_CYCLES, default 1000000: consecutive stable samples required to accept a change (20 ms at 50 MHz). Legal range ≥ 2.
- CNT_WIDTH, default 20: width of each debounce counter. Must satisfy 2^CNT_WIDTH ≥ STABLE_CYCLES.

Ports:
- CLKFPGA, input, 1: board clock; the only clock in the block.
- Reset, input, 1: reset; synchronous, active-high.
- KEY, input, 1: raw push button, active-low (0 = pressed), asynchronous.
- SW, input, 1: raw mode switch (1 = manual), asynchronous.
- CLKManual, output, 1: debounced button level (1 = pressed), registered.
- CLKManualPulse, output, 1: one-CLKFPGA-cycle pulse on each accepted press.
- CTRLCLK, output, 1: debounced switch level, registered.
- PressCount, output, 8: number of accepted presses, wraps.

## Operation
- Synchroniser: two flops per input, giving key_s and sw_s.
  - Reset loads KEY flops to 1 and SW flops to 0.
- Button FSM, states RELEASED / PRESS_CHK / PRESSED / RELEASE_CHK, with one counter bcnt:
  - RELEASED:
    - key_s=0 → PRESS_CHK, bcnt←0.
  - PRESS_CHK:
    - key_s=1 → RELEASED (bounce rejected).
    - Else bcnt=STABLE_CYCLES-1 → PRESSED. On this transition: CLKManual←1, CLKManualPulse←1 for that cycle only, PressCount←PressCount+1.
    - Else bcnt←bcnt+1.
  - PRESSED:
    - key_s=1 → RELEASE_CHK, bcnt←0.
  - RELEASE_CHK:
    - key_s=0 → PRESSED (CLKManual stays 1, no pulse, no count).
    - Else bcnt=STABLE_CYCLES-1 → RELEASED, CLKManual←0.
    - Else bcnt←bcnt+1.
- CLKManual is 1 exactly in PRESSED and RELEASE_CHK.
- Switch filter, with counter scnt:
  - sw_s=CTRLCLK → scnt←0.
  - Otherwise, if scnt=STABLE_CYCLES-1 → CTRLCLK←sw_s, scnt←0.
  - Otherwise scnt←scnt+1.
- PressCount is 8-bit unsigned and wraps 255→0 with no flag.
- Button path and switch path are independent; simultaneous events on both are each handled in the same cycle.
- Reset (any cycle, including mid-count):
  - FSM←RELEASED, bcnt←0, scnt←0.
  - CLKManual←0, CLKManualPulse←0, CTRLCLK←0, PressCount←0.
  - A press in progress is discarded; no pulse is emitted.

## Timing
- Reset values: CLKManual=0, CLKManualPulse=0, CTRLCLK=0 (divided-clock mode), PressCount=0.
- Let S = STABLE_CYCLES and edge 1 = the first CLKFPGA edge sampling KEY low.
  - If KEY stays low, CLKManual rises after edge S+3.
  - CLKManualPulse and the PressCount increment occur at that same edge; the pulse lasts exactly one cycle.
- Release path: after edge 1 samples KEY high, CLKManual falls after edge S+3 if KEY stays high.
- Switch path: with SW changed and stable, CTRLCLK changes after edge S+2.
- Any opposite sample before acceptance restarts the qualification. A glitch shorter than S cycles never changes an output.
- At most one pulse per accepted press, however long the button is held.
- CLKManual toggles at ≤ 1/(2S) of CLKFPGA, so the downstream selector never sees bounce.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset then idle (KEY=1, SW=0) for 20 cycles → CLKManual=0, CLKManualPulse=0, CTRLCLK=0, PressCount=0 throughout.
- KEY low held 20 cycles, then high → CLKManual rises after edge 7, one CLKManualPulse at edge 7, PressCount=1, CLKManual falls 7 edges after the release is first sampled.
- KEY bounce (low 3 cycles, high 1, low 3, high) → no change on CLKManual, no pulse, PressCount stays 0.
- Release bounce while pressed (high 2 cycles, then low) → CLKManual stays 1, no second pulse, PressCount unchanged.
- 256 clean presses → PressCount returns to 0 and exactly 256 pulses are counted.
- SW 0→1 stable → CTRLCLK=1 after edge 6. Reset asserted while in PRESS_CHK with bcnt=2 → next cycle all outputs at reset values and no pulse is emitted.
